// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } deb_state_t;

  // 10 ms debounce and 1 s long press at 25 MHz
  localparam int DEF_DEBOUNCE_CYCLES   = 250000;
  localparam int DEF_LONG_PRESS_CYCLES = 25000000;
  localparam int DEF_SYNC_STAGES       = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// Generic N-flop synchronizer for a single asynchronous bit.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_synchronizer: STAGES must be >= 2");
  end

  logic [STAGES-1:0] q;

  // shift the pad value through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= {q[STAGES-2:0], i_d};
  end

  assign o_q = q[STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronizes a bouncy pad, requires DEBOUNCE_CYCLES of
// stable input before changing o_switch, and emits press/release strobes.
// Optional long-press strobe built when SWITCH_DEBOUNCER_LONG_PRESS_EN is
// defined; otherwise o_long is tied low.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_switch,
  output logic o_switch,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("switch_debouncer: SYNC_STAGES must be >= 2");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("switch_debouncer: LONG_PRESS_CYCLES must be >= 1");
  end

  localparam int          CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          s;
  deb_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sw_n, rise_n, fall_n;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_switch),
    .o_q (s)
  );

  // state, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STABLE_LOW;
      cnt      <= '0;
      o_switch <= 1'b0;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      o_switch <= sw_n;
      o_rise   <= rise_n;
      o_fall   <= fall_n;
    end
  end

  // next state; counter restarts on every mismatch, commits at CNT_MAX
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      STABLE_LOW: begin
        if (s) begin state_n = PEND_HIGH; cnt_n = CW'(1); end
        else   cnt_n = '0;
      end
      PEND_HIGH: begin
        if (!s)                  begin state_n = STABLE_LOW;  cnt_n = '0; end
        else if (cnt == CNT_MAX) begin state_n = STABLE_HIGH; cnt_n = '0; end
        else                     cnt_n = cnt + 1'b1;
      end
      STABLE_HIGH: begin
        if (!s) begin state_n = PEND_LOW; cnt_n = CW'(1); end
        else    cnt_n = '0;
      end
      PEND_LOW: begin
        if (s)                   begin state_n = STABLE_HIGH; cnt_n = '0; end
        else if (cnt == CNT_MAX) begin state_n = STABLE_LOW;  cnt_n = '0; end
        else                     cnt_n = cnt + 1'b1;
      end
      default: begin state_n = STABLE_LOW; cnt_n = '0; end
    endcase
  end

  // output decode: level follows the debounced side, strobes on commit only
  always_comb begin
    sw_n   = (state_n == STABLE_HIGH) || (state_n == PEND_LOW);
    rise_n = (state == PEND_HIGH) && (state_n == STABLE_HIGH);
    fall_n = (state == PEND_LOW)  && (state_n == STABLE_LOW);
  end

`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
  localparam int          HW       = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hold;
  logic          hi_state;

  assign hi_state = (state == STABLE_HIGH) || (state == PEND_LOW);

  // hold counter saturates so o_long fires once per press; PEND_LOW
  // bounces keep counting because the level is still high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold   <= '0;
      o_long <= 1'b0;
    end else begin
      o_long <= 1'b0;
      if (rise_n || fall_n) begin
        hold <= '0;
      end else if (hi_state && (hold != HOLD_MAX)) begin
        hold   <= hold + 1'b1;
        o_long <= (hold == HOLD_MAX - 1'b1);
      end
    end
  end
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random bouncing,
// every cycle checked against a run-length reference model.
module tb_switch_debouncer;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LP   = 8;
`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_switch = 1'b0;
  logic o_switch, o_rise, o_fall, o_long;

  switch_debouncer #(
    .DEBOUNCE_CYCLES  (DEB),
    .SYNC_STAGES      (SYNC),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_switch (i_switch),
    .o_switch (o_switch),
    .o_rise   (o_rise),
    .o_fall   (o_fall),
    .o_long   (o_long)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: pad samples delayed SYNC edges; the level flips once
  // the delayed value has disagreed with it on DEB+1 consecutive edges
  int   pipe[$];
  logic m_level;
  int   m_run, m_hold;
  logic m_rise, m_fall, m_long;

  // activity tallies for directed scenarios
  int rise_cnt, fall_cnt, long_cnt;
  int last_rise_cyc, last_fall_cyc, last_long_cyc;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < SYNC; i++) pipe.push_back(0);
    m_level = 1'b0; m_run = 0; m_hold = 0;
    m_rise = 1'b0; m_fall = 1'b0; m_long = 1'b0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    int   seen;
    logic commit;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      seen = pipe.pop_front();
      pipe.push_back(int'(i_switch));
      m_rise = 1'b0; m_fall = 1'b0; m_long = 1'b0;
      m_run  = (seen != int'(m_level)) ? m_run + 1 : 0;
      commit = (m_run == DEB + 1);
`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
      if (commit) m_hold = 0;
      else if (m_level && m_hold < LP) begin
        m_hold++;
        m_long = (m_hold == LP);
      end
`endif
      if (commit) begin
        m_level = ~m_level;
        m_rise  = m_level;
        m_fall  = ~m_level;
        m_run   = 0;
      end
    end
    #1;
    chk("o_switch", o_switch, m_level);
    chk("o_rise",   o_rise,   m_rise);
    chk("o_fall",   o_fall,   m_fall);
    chk("o_long",   o_long,   m_long);
    if (o_rise) begin rise_cnt++; last_rise_cyc = cyc; end
    if (o_fall) begin fall_cnt++; last_fall_cyc = cyc; end
    if (o_long) begin long_cnt++; last_long_cyc = cyc; end
  end

  task automatic clr_tally();
    rise_cnt = 0; fall_cnt = 0; long_cnt = 0;
    last_rise_cyc = -1000; last_fall_cyc = -1000; last_long_cyc = -1000;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0;
    clr_tally();
    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_async_sw",   o_switch, 1'b0);
    chk("rst_async_rise", o_rise,   1'b0);
    chk("rst_async_long", o_long,   1'b0);
    step(3);
    rst = 1'b0;
    step(5);

    // clean press then release
    clr_tally();
    i_switch = 1'b1; t0 = cyc + 1;
    step(20);
    chk("press_latency", last_rise_cyc - t0, 6);
    chk("press_rises",   rise_cnt, 1);
    chk("press_falls",   fall_cnt, 0);
    i_switch = 1'b0; t0 = cyc + 1;
    step(20);
    chk("release_latency", last_fall_cyc - t0, 6);
    chk("release_falls",   fall_cnt, 1);
    chk("cycle_rises",     rise_cnt, 1);

    // bounce reject: high 3 / low 1, five times
    clr_tally();
    for (int k = 0; k < 5; k++) begin
      i_switch = 1'b1; step(3);
      i_switch = 1'b0; step(1);
    end
    step(10);
    chk("bounce_rises", rise_cnt, 0);
    chk("bounce_falls", fall_cnt, 0);
    chk("bounce_level", o_switch, 1'b0);

    // bounce then settle
    clr_tally();
    i_switch = 1'b1; step(2);
    i_switch = 1'b0; step(1);
    i_switch = 1'b1; t0 = cyc + 1;
    step(20);
    chk("settle_latency", last_rise_cyc - t0, 6);
    chk("settle_rises",   rise_cnt, 1);

    // reset during a pending release clears a high output at once
    i_switch = 1'b0; step(3);
    #2 rst = 1'b1;
    #1 chk("rst_mid_sw", o_switch, 1'b0);
    // reset during a pending press, then full re-qualification
    step(1);
    rst = 1'b0;
    step(2);
    i_switch = 1'b1; step(3);
    #2 rst = 1'b1;
    #1 chk("rst_pend_sw", o_switch, 1'b0);
    step(2);
    clr_tally();
    rst = 1'b0; t0 = cyc + 1;
    step(20);
    chk("rst_requal_latency", last_rise_cyc - t0, 6);
    chk("rst_requal_rises",   rise_cnt, 1);
    i_switch = 1'b0; step(15);

    // long press
    clr_tally();
    i_switch = 1'b1; step(50);
    chk("long_count", long_cnt, EXP_LONG);
`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
    chk("long_latency", last_long_cyc - last_rise_cyc, LP);
`endif
    i_switch = 1'b0; step(15);

    // random bouncing with occasional resets
    for (int k = 0; k < 300; k++) begin
      i_switch = 1'($urandom_range(0, 1));
      step($urandom_range(1, 12));
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0;
      end
    end
    step(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream conditioning stage for the push-button toggle logic.
- Takes a raw, asynchronous, bouncy switch pad.
- Produces a synchronized, debounced level plus single-cycle press/release strobes.
- The downstream toggle stage consumes o_switch (or o_fall directly) instead of the raw pad. This removes the double-toggle seen on contact bounce.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles required before the debounced level changes (10 ms at 25 MHz). Must be >= 1; elaboration error otherwise.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer. Must be >= 2; elaboration error otherwise.
- LONG_PRESS_CYCLES, 25000000, clk cycles o_switch must stay high before o_long fires. Used only with the optional feature. Must be >= 1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; asynchronous assert, active-high.
- i_switch  input  1  raw switch pad; asynchronous to clk, may bounce.
- o_switch  output  1  debounced, synchronized switch level.
- o_rise  output  1  one-cycle strobe when o_switch goes 0->1 (press).
- o_fall  output  1  one-cycle strobe when o_switch goes 1->0 (release).
- o_long  output  1  one-cycle long-press strobe; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset: all synchronizer flops = 0, counter = 0, FSM = STABLE_LOW, o_switch = o_rise = o_fall = o_long = 0.
  - Outputs clear immediately on rst assertion, with no clk edge needed.
- Synchronizer: i_switch passes through SYNC_STAGES flops. The last stage is s. Only s is used by the FSM.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). Increments only while the FSM is pending; it never wraps.
- FSM states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
  - STABLE_LOW: s=1 -> PEND_HIGH, counter <= 1; else stay, counter <= 0.
  - PEND_HIGH: s=0 -> STABLE_LOW, counter <= 0 (bounce rejected, no strobe). s=1 and counter == DEBOUNCE_CYCLES -> STABLE_HIGH, o_switch <= 1, o_rise <= 1. Otherwise counter++.
  - STABLE_HIGH / PEND_LOW: mirror images of the above, producing o_switch <= 0 and o_fall <= 1.
  - DEBOUNCE_CYCLES=1: PEND is entered with counter=1, so the transition commits on the next edge.
- Latency:
  - o_switch changes exactly SYNC_STAGES + DEBOUNCE_CYCLES clk edges after a clean i_switch edge that is sampled on an edge.
  - o_rise/o_fall are registered and assert in the same cycle o_switch first shows the new level.
- o_rise, o_fall and o_long are each high for exactly one cycle. o_rise and o_fall are never high together.
- A glitch shorter than DEBOUNCE_CYCLES in either stable state produces no output change and no strobe. The counter restarts from zero on every mismatch.
- Reset mid-pending: the pending transition is discarded. After rst deasserts with i_switch held high, a full SYNC_STAGES + DEBOUNCE_CYCLES is needed before o_switch=1, and o_rise fires then.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_LONG_PRESS_EN.
- Defined:
  - A hold counter clears on o_rise and increments each cycle in STABLE_HIGH/PEND_LOW. It saturates at LONG_PRESS_CYCLES.
  - o_long pulses once, on the cycle the counter reaches LONG_PRESS_CYCLES. There is no repeat while held.
  - The hold counter is cleared on o_fall and on rst.
  - A PEND_LOW bounce does not reset the hold count.
- Undefined: no hold counter is built; o_long is driven constant 0. The port list is identical in both builds.

Decomposition:
- Package switch_debouncer_pkg:
  - typedef enum logic [1:0] deb_state_t {STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW}.
  - Default localparams DEF_DEBOUNCE_CYCLES and DEF_LONG_PRESS_CYCLES.
- Sub-module bit_synchronizer (parameter STAGES; ports clk, rst, i_d, o_q): generic N-flop CDC synchronizer, reusable for other pad inputs.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_PRESS_CYCLES=8):
- Clean press: i_switch 0->1, held 20 cycles -> o_switch=1 exactly 6 edges later; o_rise high that one cycle only; o_fall stays 0.
- Bounce reject: i_switch toggles high 3 / low 1, repeated 5 times, then low -> o_switch, o_rise and o_fall stay 0 throughout.
- Bounce then settle: high 2, low 1, then high held -> o_switch=1 exactly 6 edges after the final rising edge; exactly one o_rise.
- Release: from debounced high, i_switch 1->0 held -> o_switch=0 after 6 edges with a single o_fall pulse. Press-then-release yields exactly 1 o_rise and 1 o_fall.
- Reset mid-pending: i_switch high, rst pulsed 3 cycles after the edge -> outputs 0 immediately; after rst deasserts, o_switch=1 exactly 6 edges after deassertion.
- Long press (macro on): hold high for 50 cycles -> one o_long pulse 8 cycles after o_rise, then none. Macro off -> o_long stays 0 for the whole run.
